// File: rtl/ls_logic_unit_pkg.sv
// rtl/ls_logic_unit_pkg.sv - op-code constants shared by the logic unit slice
// Purpose: names for the 3-bit operation select of ls_logic_unit.
// Ports: none (package).
package ls_logic_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_NAND = 3'b011;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_PASA = 3'b110;
  localparam logic [OP_W-1:0] OP_NOTA = 3'b111;

endpackage

// File: rtl/ls_logic_unit_if.sv
// rtl/ls_logic_unit_if.sv - operand/result bundle for ls_logic_unit
// Purpose: groups the input handshake, operands, accumulator controls and
// the registered output stage of the logic unit.
// Ports (signals): in_valid/in_ready, op, acc_en, acc_clr, a, b,
//   out_valid/out_ready, y, zero, acc.
// Modports: master drives operands and out_ready; slave is the unit.
interface ls_logic_unit_if #(
  parameter int WIDTH = 4
);
  import ls_logic_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic             acc_en;
  logic             acc_clr;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, acc_en, acc_clr, a, b, out_ready,
    input  in_ready, out_valid, y, zero, acc
  );

  modport slave (
    input  in_valid, op, acc_en, acc_clr, a, b, out_ready,
    output in_ready, out_valid, y, zero, acc
  );

endinterface

// File: rtl/ls_logic_unit_core.sv
// rtl/ls_logic_unit_core.sv - combinational bitwise logic function
// Purpose: WIDTH-bit two-operand bitwise function selected by op.
// Ports: op (in, 3), a (in, WIDTH), b (in, WIDTH), result (out, WIDTH).
module ls_logic_core
  import ls_logic_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      OP_PASA: result = a;
      OP_NOTA: result = ~a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ls_logic_unit.sv
// rtl/ls_logic_unit.sv - registered logic unit with accumulator and zero flag
// Purpose: accepts (op, a, b) under valid/ready, produces a registered result
// one cycle later in a one-deep output stage, optionally chaining through an
// internal accumulator that replaces operand A.
// Ports: clk (in), rst (in, sync active-high), bus (ls_logic_unit_if.slave).
module ls_logic_unit
  import ls_logic_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  ls_logic_unit_if.slave     bus
);

  logic             out_valid_q;
  logic [WIDTH-1:0] y_q;
  logic             zero_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] result;
  logic             accept;

  // A same-cycle clear feeds ACC_RESET into the op, so a chain can restart
  // without spending a cycle on the clear. With acc_en set, a is never used,
  // which keeps an undriven a from reaching the result.
  always_comb begin
    opnd_a = bus.a;
    if (bus.acc_en) begin
      opnd_a = bus.acc_clr ? ACC_RESET : acc_q;
    end
  end

  ls_logic_core #(.WIDTH(WIDTH)) u_core (
    .op     (bus.op),
    .a      (opnd_a),
    .b      (bus.b),
    .result (result)
  );

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b1;
      acc_q       <= ACC_RESET;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        y_q         <= result;
        zero_q      <= (result == '0);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A chained write-back wins over a clear issued in the same cycle.
      if (accept && bus.acc_en) begin
        acc_q <= result;
      end else if (bus.acc_clr) begin
        acc_q <= ACC_RESET;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.acc       = acc_q;

endmodule

// File: doc/ls_logic_unit.md
Name: ls_logic_unit

Overview:
- Parametrised, registered successor to the quad 2-input gate chips: WIDTH-bit two-operand logic unit with a run-time op select.
- Adds a one-deep valid/ready output stage, an internal accumulator (operand A replaced by the previous result) and a registered zero flag.
- Used by the CPU datapath as its bitwise-logic slice, alongside the gate-level parts.

Parameters:
- WIDTH, 4, operand/result width in bits (legal range 1..32).
- ACC_RESET, 0, accumulator value after reset or acc_clr (WIDTH bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset: synchronous, active-high; single clock domain.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit can accept this cycle.
- op  in  3  operation code (see Behaviour).
- acc_en  in  1  use accumulator as operand A and write result back to it.
- acc_clr  in  1  clear accumulator to ACC_RESET.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  y holds an unconsumed result.
- out_ready  in  1  consumer accepts y this cycle.
- y  out  WIDTH  registered result.
- zero  out  1  registered, equals (y == 0).
- acc  out  WIDTH  current accumulator contents.

Behaviour:
- Op codes: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 PASS A, 111 NOT A. All ops are bitwise, no carries, and the result is exactly WIDTH bits.
- Reset (rst=1 at a clk edge) forces:
  - out_valid=0, y=0, zero=1, acc=ACC_RESET.
  - rst overrides every other input in that cycle; any result held in the output stage is discarded.
- in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
- Accept happens when in_valid && in_ready. Latency is 1 cycle: on the edge after accept, y=result, zero=(result==0), out_valid=1. Throughput is 1 result per cycle while out_ready=1.
- Hold: while out_valid && !out_ready, y, zero and out_valid stay stable and no input is accepted.
- Drain: out_ready && out_valid with no accept in the same cycle gives out_valid=0 next cycle. y keeps its last value.
- Operand A selection:
  - acc_en=0: A = a.
  - acc_en=1: A = acc. If acc_clr=1 in the same cycle, A = ACC_RESET instead.
- Accumulator update, evaluated at each edge, highest priority first:
  - Accept with acc_en=1: acc <= result. This applies even if acc_clr=1.
  - acc_clr=1 otherwise: acc <= ACC_RESET. This applies whether or not there is an accept.
  - Otherwise: acc holds. An accept with acc_en=0 does not change acc.
- acc_en and acc_clr are ignored unless sampled in a cycle where acc_clr=1 or an accept occurs. acc_clr never alters y or out_valid.
- Invalid op values do not exist (3-bit fully decoded). No X may propagate from a or b when acc_en=1, since a is then unused.

Decomposition:
- Package ls_logic_pkg holds the op-code localparams (OP_AND … OP_NOTA) and the op width constant (3).
- Sub-module ls_logic_core: purely combinational, WIDTH-parametrised, takes (op, a, b) and produces the result. The top level contains only the handshake register, the accumulator and the zero flag.

Test Plan:
- WIDTH=4, op=OR, a=1010, b=0101, out_ready=1: next cycle y=1111, zero=0, out_valid=1. Then a=1100, b=0011 gives y=1111; op=AND on the same operands gives y=0000, zero=1.
- Backpressure: accept XOR 0110^0011, hold out_ready=0 for 3 cycles with new in_valid. Required: in_ready=0, y=0101 stable throughout. Raise out_ready: the pending input is accepted the same cycle and its result appears the next cycle.
- Accumulate chain with ACC_RESET=0, acc_en=1, op=OR, b=0001, then 0010, then 1000: acc becomes 0001, then 0011, then 1011, and each y equals the new acc. Then op=NOT A gives y=0100.
- Simultaneous events:
  - acc=1011 with acc_clr=1, acc_en=1, op=XOR, b=0110 accepted: y=0110, acc=0110.
  - acc_clr=1 with no accept: acc=0000, y unchanged.
- Reset mid-operation: with out_valid=1 held by out_ready=0 and acc=1011, pulse rst for one cycle. Next cycle out_valid=0, y=0000, zero=1, acc=ACC_RESET, in_ready=1.
- WIDTH=8, ACC_RESET=8'hFF, op=NAND, a=8'hF0, b=8'h3C: y=8'hCF. After rst, acc=8'hFF.
